// File: rtl/ad9866_spi_master.sv
// AD9866 4-wire SPI configuration master.
// Replays a power-up register table, then arbitrates round-robin among
// NUM_REQ register-access requesters and shifts 16-bit frames
// {rd, 2'b00, addr[4:0], data[7:0]} MSB first.
//
// Optional feature macro: AD9866_SPI_READBACK_EN
//   defined   : read requests capture sdo and return rdata/rvalid
//   undefined : every request is a write, rdata = 0, rvalid = 0
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   req/req_rd            per-channel request level and read flag
//   req_addr/req_wdata    packed per-channel address (5b) and write data (8b)
//   ack                   one-cycle completion pulse to the granted channel
//   rdata/rvalid          read-back data and its one-cycle strobe
//   init_done             sticky, set once the init table has been replayed
//   busy                  high unless idle with init complete
//   sclk/sdio/sdo/sen_n   SPI pins
module ad9866_spi_master #(
  parameter int NUM_REQ    = 2,
  parameter int INIT_DEPTH = 20,
  parameter logic [INIT_DEPTH-1:0][8:0] INIT_TABLE = '0,
  parameter int CLK_DIV    = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rd,
  input  logic [5*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             rdata,
  output logic                   rvalid,
  output logic                   init_done,
  output logic                   busy,
  output logic                   sclk,
  output logic                   sdio,
  input  logic                   sdo,
  output logic                   sen_n
);

  localparam int PW = (NUM_REQ > 1)    ? $clog2(NUM_REQ)    : 1;
  localparam int AW = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;
  localparam int IW = $clog2(INIT_DEPTH + 1);
  localparam int DW = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;

  typedef enum logic [1:0] {INIT_FETCH, IDLE, SHIFT, GAP} state_t;

  state_t              state, state_d;
  logic [IW-1:0]       idx, idx_d;
  logic                done_q, done_d;
  logic [PW-1:0]       rr_ptr, rr_d, grant, grant_d, gnt, cand;
  logic                host, host_d, found, rd_sel;
  logic [15:0]         shreg, shreg_d, shift_nx;
  logic                sclk_q, sclk_d, sen_q, sen_d, busy_q, busy_d, shift_in;
  logic [DW-1:0]       div_cnt, div_d;
  logic [3:0]          fall_cnt, fall_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [8:0]          ent;

`ifdef AD9866_SPI_READBACK_EN
  logic                rd_q, rd_d, rvalid_q, rvalid_d;
  logic [7:0]          rdata_q, rdata_d;
  assign shift_in = sdo;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
`else
  logic                unused_rb;
  assign unused_rb = ^{sdo, req_rd};
  assign shift_in  = 1'b0;
  assign rdata     = 8'h00;
  assign rvalid    = 1'b0;
`endif

  assign ack       = ack_q;
  assign init_done = done_q;
  assign busy      = busy_q;
  assign sclk      = sclk_q;
  assign sen_n     = sen_q;
  // shreg is cleared at frame end, so sdio idles low between frames
  assign sdio      = shreg[15];

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    done_d   = done_q;
    rr_d     = rr_ptr;
    grant_d  = grant;
    host_d   = host;
    shreg_d  = shreg;
    sclk_d   = sclk_q;
    sen_d    = sen_q;
    div_d    = div_cnt;
    fall_d   = fall_cnt;
    ack_d    = '0;
`ifdef AD9866_SPI_READBACK_EN
    rd_d     = rd_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
`endif
    shift_nx = {shreg[14:0], shift_in};
    ent      = INIT_TABLE[idx[AW-1:0]];

    // first requester at or after rr_ptr, wrapping
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
`ifdef AD9866_SPI_READBACK_EN
    rd_sel = req_rd[gnt];
`else
    rd_sel = 1'b0;
`endif

    case (state)
      INIT_FETCH: begin
        if (idx == IW'(INIT_DEPTH)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx + 1'b1;
          if (ent[8]) begin
            shreg_d = {1'b0, 2'b00, 5'(idx), ent[7:0]};
            host_d  = 1'b0;
`ifdef AD9866_SPI_READBACK_EN
            rd_d    = 1'b0;
`endif
            sen_d   = 1'b0;
            sclk_d  = 1'b0;
            div_d   = '0;
            fall_d  = '0;
            state_d = SHIFT;
          end
        end
      end
      IDLE: begin
        if (found) begin
          shreg_d = {rd_sel, 2'b00, req_addr[int'(gnt)*5 +: 5],
                     rd_sel ? 8'h00 : req_wdata[int'(gnt)*8 +: 8]};
          host_d  = 1'b1;
          grant_d = gnt;
          rr_d    = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
`ifdef AD9866_SPI_READBACK_EN
          rd_d    = rd_sel;
`endif
          sen_d   = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          fall_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          if (sclk_q) begin
            // falling edge: shift out next bit, capture sdo
            shreg_d = shift_nx;
            fall_d  = fall_cnt + 4'd1;
            if (fall_cnt == 4'd15) begin
              shreg_d = '0;
              sen_d   = 1'b1;
              state_d = GAP;
              if (host) ack_d[grant] = 1'b1;
`ifdef AD9866_SPI_READBACK_EN
              if (host && rd_q) begin
                rvalid_d = 1'b1;
                rdata_d  = shift_nx[7:0];
              end
`endif
            end
          end
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end
      GAP: begin
        // sen_n stays high for this cycle plus the following fetch/arbitration
        // cycle, giving the 2-cycle minimum between frames
        state_d = done_q ? IDLE : INIT_FETCH;
      end
      default: state_d = INIT_FETCH;
    endcase

    busy_d = !(state_d == IDLE && done_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= INIT_FETCH;
      idx      <= '0;
      done_q   <= 1'b0;
      rr_ptr   <= '0;
      grant    <= '0;
      host     <= 1'b0;
      shreg    <= '0;
      sclk_q   <= 1'b0;
      sen_q    <= 1'b1;
      div_cnt  <= '0;
      fall_cnt <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
`ifdef AD9866_SPI_READBACK_EN
      rd_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
`endif
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      done_q   <= done_d;
      rr_ptr   <= rr_d;
      grant    <= grant_d;
      host     <= host_d;
      shreg    <= shreg_d;
      sclk_q   <= sclk_d;
      sen_q    <= sen_d;
      div_cnt  <= div_d;
      fall_cnt <= fall_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
`ifdef AD9866_SPI_READBACK_EN
      rd_q     <= rd_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
`endif
    end
  end

endmodule

// File: tb/tb_ad9866_spi_master.sv
// Directed bench for ad9866_spi_master: init replay, write, read,
// round-robin, CLK_DIV=3 timing and mid-frame reset.
module tb_ad9866_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // entries 0 (0x80) and 7 (0x21) enabled, all others skipped
  localparam logic [19:0][8:0] TBL = {{12{9'h000}}, 9'h121, {6{9'h000}}, 9'h180};

  logic        reset_n;
  logic [1:0]  req, req_rd, ack;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rdata;
  logic        rvalid, init_done, busy, sclk, sdio, sdo, sen_n;

  logic        req3, ack3, rvalid3, init_done3, busy3, sclk3, sdio3, sen3_n;
  logic        req3_rd = 1'b0;
  logic        sdo3 = 1'b0;
  logic [4:0]  req3_addr;
  logic [7:0]  req3_wdata, rdata3;

  ad9866_spi_master #(.NUM_REQ(2), .INIT_DEPTH(20), .INIT_TABLE(TBL), .CLK_DIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_rd(req_rd), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .rvalid(rvalid),
    .init_done(init_done), .busy(busy), .sclk(sclk), .sdio(sdio), .sdo(sdo), .sen_n(sen_n));

  ad9866_spi_master #(.NUM_REQ(1), .INIT_DEPTH(20), .INIT_TABLE(TBL), .CLK_DIV(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .req_rd(req3_rd), .req_addr(req3_addr),
    .req_wdata(req3_wdata), .ack(ack3), .rdata(rdata3), .rvalid(rvalid3),
    .init_done(init_done3), .busy(busy3), .sclk(sclk3), .sdio(sdio3), .sdo(sdo3), .sen_n(sen3_n));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- SPI slave model / frame monitor for dut ----
  logic [7:0]  rd_byte = 8'h00;
  logic [15:0] frm;
  logic        pv_sen, pv_sclk;
  int          len, rises, gap_len;
  int          ack_cnt0, ack_cnt1;
  logic [15:0] frames[$];
  int          lens[$], gaps[$], grants[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      len = 0; rises = 0; gap_len = 0; frm = '0; sdo = 1'b0;
      pv_sen = 1'b1; pv_sclk = 1'b0; ack_cnt0 = 0; ack_cnt1 = 0;
    end else begin
      if (!sen_n) begin
        if (pv_sen) begin gaps.push_back(gap_len); len = 0; rises = 0; end
        len++;
        if (sclk && !pv_sclk) begin
          frm = {frm[14:0], sdio};
          rises++;
          // data byte returned MSB first during the last 8 bit times
          sdo = (rises >= 9) ? rd_byte[3'(16 - rises)] : 1'b0;
        end
      end else begin
        if (!pv_sen) begin frames.push_back(frm); lens.push_back(len); gap_len = 0; end
        gap_len++;
      end
      if (ack[0]) begin ack_cnt0++; grants.push_back(0); end
      if (ack[1]) begin ack_cnt1++; grants.push_back(1); end
      pv_sen = sen_n; pv_sclk = sclk;
    end
  end

  // ---- monitor for dut3 (CLK_DIV=3) ----
  logic [15:0] frm3;
  logic        pv_sen3, pv_sclk3;
  int          len3, cyc3, last_rise3;
  logic [15:0] frames3[$];
  int          lens3[$], per3[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      len3 = 0; cyc3 = 0; last_rise3 = -1; frm3 = '0; pv_sen3 = 1'b1; pv_sclk3 = 1'b0;
    end else begin
      cyc3++;
      if (!sen3_n) begin
        if (pv_sen3) begin len3 = 0; last_rise3 = -1; end
        len3++;
        if (sclk3 && !pv_sclk3) begin
          frm3 = {frm3[14:0], sdio3};
          if (last_rise3 >= 0) per3.push_back(cyc3 - last_rise3);
          last_rise3 = cyc3;
        end
      end else if (!pv_sen3) begin
        frames3.push_back(frm3); lens3.push_back(len3);
      end
      pv_sen3 = sen3_n; pv_sclk3 = sclk3;
    end
  end

  task automatic wait_ack(input logic [1:0] mask, input int bound, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (((ack & mask) == 2'b00) && cyc < bound);
  endtask

  task automatic wait_init(input int bound);
    int c = 0;
    while (!init_done && c < bound) begin @(negedge clk); c++; end
  endtask

  task automatic clr_q();
    frames.delete(); lens.delete(); gaps.delete(); grants.delete();
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; req = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
    req3 = 1'b0; req3_addr = '0; req3_wdata = '0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_sdio", sdio, 1'b0);
    chk("rst_sen_n", sen_n, 1'b1);
    chk("rst_ack", ack, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // init replay: entry 0 launches at the first edge after release
    reset_n = 1'b1;
    @(negedge clk);
    chk("init_busy", busy, 1'b1);
    chk("init_first_sen", sen_n, 1'b0);
    wait_init(300);
    chk("init_done", init_done, 1'b1);
    repeat (2) @(negedge clk);
    chk("init_nframes", frames.size(), 2);
    chk("init_frame0", frames[0], 16'h0080);
    chk("init_frame1", frames[1], 16'h0721);
    chk("init_len0", lens[0], 32);
    chk("init_no_ack", ack_cnt0 + ack_cnt1, 0);
    chk("idle_busy", busy, 1'b0);
    clr_q();

    // write addr 0x09 data 0x5A on channel 0
    req_addr = {5'h00, 5'h09}; req_wdata = {8'h00, 8'h5A}; req_rd = 2'b00; req = 2'b01;
    @(negedge clk);
    chk("wr_sen_low", sen_n, 1'b0);
    chk("wr_sdio_b15", sdio, 1'b0);
    wait_ack(2'b01, 100, cyc);
    chk("wr_ack_lat", cyc, 32);
    chk("wr_ack_chan", ack, 2'b01);
    chk("wr_sen_rise", sen_n, 1'b1);
    req = 2'b00;
    repeat (3) @(negedge clk);
    chk("wr_frame", frames[0], 16'h095A);
    chk("wr_len", lens[0], 32);
    chk("wr_ack_once", ack_cnt0, 1);
    clr_q();

    // read addr 0x0B, slave returns 0xC3
    rd_byte = 8'hC3;
    req_addr = {5'h00, 5'h0B}; req_wdata = '0; req_rd = 2'b01; req = 2'b01;
    @(negedge clk);
`ifdef AD9866_SPI_READBACK_EN
    chk("rd_sdio_b15", sdio, 1'b1);
`else
    chk("rd_sdio_b15", sdio, 1'b0);
`endif
    wait_ack(2'b01, 100, cyc);
    chk("rd_ack_lat", cyc, 32);
`ifdef AD9866_SPI_READBACK_EN
    chk("rd_rvalid", rvalid, 1'b1);
    chk("rd_rdata", rdata, 8'hC3);
`else
    chk("rd_rvalid", rvalid, 1'b0);
    chk("rd_rdata", rdata, 8'h00);
`endif
    req = 2'b00; req_rd = 2'b00;
    @(negedge clk);
    chk("rd_rvalid_pulse", rvalid, 1'b0);
    repeat (2) @(negedge clk);
`ifdef AD9866_SPI_READBACK_EN
    chk("rd_frame", frames[0], 16'h8B00);
`else
    chk("rd_frame", frames[0], 16'h0B00);
`endif
    clr_q();

    // round robin, both held: rr_ptr is 1 after two channel-0 grants
    req_addr = {5'h02, 5'h01}; req_wdata = {8'h22, 8'h11}; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(2'b11, 100, cyc);
      chk($sformatf("rr_lat%0d", k), cyc, (k == 0) ? 33 : 34);
      if (k == 3) req = 2'b00;
    end
    repeat (3) @(negedge clk);
    chk("rr_grant0", grants[0], 1);
    chk("rr_grant1", grants[1], 0);
    chk("rr_grant2", grants[2], 1);
    chk("rr_grant3", grants[3], 0);
    chk("rr_frame0", frames[0], 16'h0222);
    chk("rr_frame1", frames[1], 16'h0111);
    chk("rr_gap1", gaps[1], 2);
    chk("rr_gap3", gaps[3], 2);
    clr_q();

    // CLK_DIV=3 instance
    begin
      int c = 0;
      while (!init_done3 && c < 600) begin @(negedge clk); c++; end
    end
    chk("d3_init_done", init_done3, 1'b1);
    frames3.delete(); lens3.delete(); per3.delete();
    req3_addr = 5'h03; req3_wdata = 8'hA5; req3 = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!ack3 && cyc < 300);
    chk("d3_ack_lat", cyc, 97);
    req3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("d3_frame", frames3[0], 16'h03A5);
    chk("d3_len", lens3[0], 96);
    chk("d3_per_first", per3[0], 6);
    chk("d3_per_last", per3[14], 6);

    // reset in the middle of a frame (bit 7 on the wire)
    req_addr = {5'h00, 5'h1F}; req_wdata = {8'h00, 8'hFF}; req = 2'b01;
    begin
      int c = 0;
      do begin @(negedge clk); #1; c++; end while (rises < 9 && c < 100);
    end
    reset_n = 1'b0; req = 2'b00;
    @(negedge clk);
    chk("mrst_sen_n", sen_n, 1'b1);
    chk("mrst_sclk", sclk, 1'b0);
    chk("mrst_ack", ack, 2'b00);
    chk("mrst_init_done", init_done, 1'b0);
    chk("mrst_rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    clr_q();
    reset_n = 1'b1;
    wait_init(300);
    repeat (2) @(negedge clk);
    chk("mrst_nframes", frames.size(), 2);
    chk("mrst_frame0", frames[0], 16'h0080);
    chk("mrst_frame1", frames[1], 16'h0721);
    chk("mrst_no_ack", ack_cnt0 + ack_cnt1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ad9866_spi_master.md
# ad9866_spi_master

Parametrised SPI configuration master for the AD9866 codec; supersedes the fixed two-source gain writer. It replays a parameterised power-up register table, then arbitrates round-robin among NUM_REQ register-access requesters (RX gain, TX gain, host control, …). It sits between the control/command decoders and the AD9866 4-wire SPI pins. It adds read-back, a programmable SCLK rate and a per-requester req/ack handshake.

## Interface
- NUM_REQ, 2, number of requester channels (1..8)
- INIT_DEPTH, 20, init table entries (1..32); entry i targets register address i
- INIT_TABLE, all {1'b0,8'h00}, [INIT_DEPTH][8:0]; bit 8 = write enable, [7:0] = value
- CLK_DIV, 1, clk cycles per SCLK half-period (>=1)
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-channel request level; held until ack
- req_rd  in  NUM_REQ  1 = read, 0 = write
- req_addr  in  5*NUM_REQ  register address, channel k at [5k+4:5k]
- req_wdata  in  8*NUM_REQ  write data, channel k at [8k+7:8k]
- ack  out  NUM_REQ  one-cycle completion pulse to the granted channel
- rdata  out  8  read-back data
- rvalid  out  1  one-cycle pulse, rdata valid
- init_done  out  1  high once the init table has been replayed
- busy  out  1  high when not in IDLE or init not done
- sclk  out  1  SPI clock
- sdio  out  1  SPI MOSI (4-wire mode)
- sdo  in  1  SPI MISO
- sen_n  out  1  SPI enable, active low

## Operation
- Frame: 16 bits, MSB first: {rd, 2'b00, addr[4:0], data[7:0]}; data is 8'h00 for reads.
- States: INIT_FETCH, IDLE, SHIFT, GAP.
- INIT_FETCH walks entries 0..INIT_DEPTH-1:
  - An entry with bit 8 = 0 costs one cycle and is skipped.
  - An entry with bit 8 = 1 launches a write to address i and returns through GAP.
  - After the last entry, init_done is set (sticky until reset) and the FSM enters IDLE.
- IDLE with any req high:
  - Grant the first requester at or after rr_ptr (wraps modulo NUM_REQ).
  - Latch rd/addr/wdata, load the shift register, drive sen_n low, go to SHIFT.
  - rr_ptr becomes grant+1 modulo NUM_REQ.
- SHIFT:
  - sclk toggles every CLK_DIV cycles, starting low.
  - On each high→low transition the shift register shifts left with sdo entering the LSB, and sdio (= shift[15]) updates.
  - After 16 falling edges: sen_n high, ack[grant] pulses; for reads, rdata = shift[7:0] and rvalid pulses in the same cycle. Go to GAP.
- GAP: sen_n held high 2 cycles, then return to INIT_FETCH (if init not done) or IDLE.
- Requests are ignored until init_done.
- Dropping req before ack is a protocol violation: the transaction completes and ack still pulses.
- A requester whose req stays high after ack is re-arbitrated (back-to-back allowed, round-robin fairness applies).

## Timing
- Reset values: sclk 0, sdio 0, sen_n 1, ack 0, rdata 0, rvalid 0, init_done 0, busy 0; rr_ptr 0; table index 0.
- Reset asserted mid-frame: all outputs take reset values at the next edge; init replays from entry 0 after release.
- Transaction latency, req sampled high in IDLE at cycle t:
  - t+1: sen_n low, sdio = frame bit 15.
  - t+1+CLK_DIV: first sclk rise.
  - t+1+32*CLK_DIV: sen_n high and ack.
  - t+3+32*CLK_DIV: earliest next sen_n fall.
- sdio is stable for CLK_DIV cycles on both sides of each sclk rise.
- sdo is sampled in the cycle sclk goes low.

## Configuration
- AD9866_SPI_READBACK_EN defined: read requests behave as above.
- AD9866_SPI_READBACK_EN undefined:
  - req_rd is ignored and every request issues a write.
  - rdata is tied 8'h00 and rvalid is tied 0.
  - The sdo capture logic is removed; shifting inserts 0.

## Test plan
- INIT_TABLE with only entries 0 (8'h80) and 7 (8'h21) enabled, CLK_DIV=1 -> exactly two frames, 16'h0080 then 16'h0721; init_done rises after entry 19 is processed; no ack pulses.
- After init, req[0] write addr 0x09 data 8'h5A -> sdio frame 16'h095A, sen_n low 32 cycles, ack[0] pulses once at the sen_n rise.
- Read addr 0x0B with model returning 8'hC3 on sdo (readback enabled) -> frame 16'h8B00, rdata 8'hC3, rvalid coincident with ack.
- req[0] and req[1] held high continuously, NUM_REQ=2 -> grants alternate 0,1,0,1; GAP of exactly 2 cycles between frames.
- CLK_DIV=3 -> sclk period 6 clk cycles, sen_n low 96 cycles per frame.
- reset_n low at bit 7 of a frame -> next edge sen_n=1, sclk=0, no ack; after release the init sequence restarts from entry 0.
